i2s_tx_sequencer: RTL and testbench
===================================

Name: i2s_tx_sequencer

Overview:
- Transmit-side controller for the APB I2S peripheral.
- When CR.I2S_ENABLE is set, pops left/right sample pairs from the TXL/TXR FIFOs and sequences SCK, WS and SD in Philips I2S format.
- When the FIFOs run dry, it finishes the frame and requests that CR.I2S_ENABLE be cleared.
- Sits between the register/FIFO block and the I2S pins.

Parameters:
- TCLK_PERIOD, 25, i_clk cycles per SCK period; legal values ≥ 4. SCK is low for floor(TCLK_PERIOD/2) cycles and high for the rest.
- DATA_WIDTH, 32, bits per channel word.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  CR.I2S_ENABLE level
- o_enable_clr  out  1  one-cycle pulse: register block clears CR.I2S_ENABLE
- i_fifol_empty  in  1  TXL FIFO empty
- i_fifor_empty  in  1  TXR FIFO empty
- i_fifol_data  in  DATA_WIDTH  TXL head word (show-ahead, valid when not empty)
- i_fifor_data  in  DATA_WIDTH  TXR head word
- o_fifol_pop  out  1  pop TXL head this cycle
- o_fifor_pop  out  1  pop TXR head this cycle
- o_sck  out  1  I2S serial clock
- o_ws  out  1  word select: 0 = left, 1 = right
- o_sd  out  1  serial data
- o_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low (i_rst_n). Reset asserts all outputs to 0, state = IDLE, and clears the counters and shift registers. Reset mid-frame aborts immediately with no pops or clear pulse.
- Pairing: a "pair available" condition means both FIFOs are non-empty. Pops are always issued on both FIFOs in the same cycle, never on one alone.
- Counters:
  - div runs 0..TCLK_PERIOD-1; o_sck = (div ≥ TCLK_PERIOD/2).
  - slot runs 0..2*DATA_WIDTH-1 and advances when div wraps (on the SCK falling edge).
- Slot outputs in TX:
  - o_ws = 0 for slots 0..DATA_WIDTH-1 and 1 for the rest.
  - o_sd in slot 0 = previous right[0], or 0 in the first frame after IDLE.
  - o_sd in slots 1..DATA_WIDTH = left[DATA_WIDTH-slot].
  - o_sd in slots DATA_WIDTH+1..2*DATA_WIDTH-1 = right[2*DATA_WIDTH-slot].
- State machine (IDLE, TX, TAIL):
  - IDLE, i_enable=1 and pair available: pop both, latch left/right into shift registers, go to TX with div=0 and slot=0.
  - IDLE, i_enable=1 and no pair available: pulse o_enable_clr, stay in IDLE.
  - TX, last cycle of slot 2*DATA_WIDTH-1: if i_enable=1 and pair available, pop and latch the new pair in that same cycle and continue TX from slot 0 with no gap. Otherwise go to TAIL.
  - TAIL: one SCK period with o_ws=0 and o_sd=right[0]. At its end, pulse o_enable_clr for exactly one cycle (issued even if i_enable is already 0), drive o_sd to 0, go to IDLE.
- i_enable falling mid-frame: the current frame completes, then TAIL; no further pops.
- Single FIFO non-empty at a frame boundary: treated as no pair available. Neither FIFO is popped, so L/R alignment is preserved.
- Pop timing: o_fifo*_pop is high for one cycle only, and data is captured on the same edge.
- Latency: first SCK rising edge occurs floor(TCLK_PERIOD/2)+1 cycles after the enable is sampled in IDLE.
- Frame duration: 2*DATA_WIDTH*TCLK_PERIOD cycles.
- Enable is ignored while in TX/TAIL until the next frame boundary.

Test Plan:
- Reset with i_enable=1 and FIFOs empty: all outputs 0. After reset, one o_enable_clr pulse within 2 cycles, no pops, o_busy stays 0.
- One pair L=32'hA5A5_0F0F, R=32'h1234_5678, defaults:
  - exactly one simultaneous pop pair;
  - o_sd sampled at SCK rising edges reproduces 0, then L MSB-first, then R;
  - o_ws toggles at slot 32;
  - 1600 cycles of TX, then a 25-cycle TAIL, then o_enable_clr, so o_busy=0 well before 2000 cycles.
- Four pairs preloaded, enable set:
  - four pop pairs spaced exactly 1600 cycles apart;
  - continuous SCK with no gap between frames;
  - slot 0 of each frame carries the previous R[0];
  - a single clear pulse after the last frame.
- TXR holds 2 words, TXL holds 1: one frame is sent, then TAIL and clear. TXR keeps 1 word and no TXR-only pop occurs.
- Deassert i_enable at slot 10 of frame 1 with 3 pairs queued: frame 1 completes, no second pop, TAIL, clear pulse, and 2 pairs remain.
- Assert i_rst_n=0 at slot 40: o_sck, o_ws, o_sd and o_busy go to 0 asynchronously. After release, restarting with enable sends the next queued pair from slot 0.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// Transmit sequencer for the APB I2S peripheral: pops L/R pairs from the TX FIFOs
// and serialises them as Philips I2S (SCK, WS, SD) until the FIFOs run dry.
module i2s_tx_sequencer #(
   parameter int TCLK_PERIOD = 25,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   output logic                  o_enable_clr,
   input  logic                  i_fifol_empty,
   input  logic                  i_fifor_empty,
   input  logic [DATA_WIDTH-1:0] i_fifol_data,
   input  logic [DATA_WIDTH-1:0] i_fifor_data,
   output logic                  o_fifol_pop,
   output logic                  o_fifor_pop,
   output logic                  o_sck,
   output logic                  o_ws,
   output logic                  o_sd,
   output logic                  o_busy
);

   localparam int DIV_W  = (TCLK_PERIOD > 1) ? $clog2(TCLK_PERIOD) : 1;
   localparam int SLOT_W = $clog2(2 * DATA_WIDTH);
   localparam int SH_W   = 2 * DATA_WIDTH;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TCLK_PERIOD - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(TCLK_PERIOD / 2);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * DATA_WIDTH - 1);
   localparam logic [SLOT_W-1:0] SLOT_RGT  = SLOT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TX   = 2'd1,
      S_TAIL = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [SH_W-1:0]    sh_q, sh_d;
   logic               slot0_q, slot0_d;
   logic               ready_q;

   logic pair_avail;
   logic div_wrap;
   logic frame_end;
   logic load;

   assign pair_avail = !i_fifol_empty && !i_fifor_empty;
   assign div_wrap   = (div_q == DIV_LAST);
   assign frame_end  = div_wrap && (slot_q == SLOT_LAST);

   // ready_q keeps IDLE from popping or clearing while reset is still being released
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         slot_q  <= '0;
         sh_q    <= '0;
         slot0_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         slot_q  <= slot_d;
         sh_q    <= sh_d;
         slot0_q <= slot0_d;
         ready_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ready_q && i_enable && pair_avail) begin
               state_d = S_TX;
               load    = 1'b1;
            end
         end
         S_TX: begin
            if (frame_end) begin
               if (i_enable && pair_avail) begin
                  load = 1'b1;
               end else begin
                  state_d = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            if (div_wrap) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Slot 0 replays the previous word's LSB, so the shifter only moves from slot 1 on;
   // the final shift of a frame leaves right[0] at the MSB for the TAIL period.
   always_comb begin
      div_d   = div_q;
      slot_d  = slot_q;
      sh_d    = sh_q;
      slot0_d = slot0_q;
      if (state_q == S_IDLE) begin
         div_d  = '0;
         slot_d = '0;
      end else begin
         div_d = div_wrap ? '0 : div_q + DIV_W'(1);
         if (div_wrap && (state_q == S_TX)) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            if (slot_q != '0) begin
               sh_d = {sh_q[SH_W-2:0], 1'b0};
            end
         end
      end
      if (load) begin
         sh_d    = {i_fifol_data, i_fifor_data};
         slot0_d = (state_q == S_TX) ? sh_q[SH_W-2] : 1'b0;
      end
   end

   always_comb begin
      o_sck        = 1'b0;
      o_ws         = 1'b0;
      o_sd         = 1'b0;
      o_enable_clr = 1'b0;
      o_fifol_pop  = load;
      o_fifor_pop  = load;
      o_busy       = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            o_enable_clr = ready_q && i_enable && !pair_avail;
         end
         S_TX: begin
            o_sck = (div_q >= DIV_HALF);
            o_ws  = (slot_q >= SLOT_RGT);
            o_sd  = (slot_q == '0) ? slot0_q : sh_q[SH_W-1];
         end
         S_TAIL: begin
            o_sck        = (div_q >= DIV_HALF);
            o_sd         = sh_q[SH_W-1];
            o_enable_clr = div_wrap;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: FIFO + enable-register model around the DUT,
// SD/WS captured on every SCK rising edge and compared with hand-built frames.
module tb_i2s_tx_sequencer;

   localparam int TCLK  = 25;
   localparam int DW    = 32;
   localparam int FRAME = 2 * DW * TCLK;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_enable;
   logic          o_enable_clr;
   logic          i_fifol_empty, i_fifor_empty;
   logic [DW-1:0] i_fifol_data, i_fifor_data;
   logic          o_fifol_pop, o_fifor_pop;
   logic          o_sck, o_ws, o_sd, o_busy;

   always #5 i_clk = ~i_clk;

   i2s_tx_sequencer #(.TCLK_PERIOD(TCLK), .DATA_WIDTH(DW)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_enable      (i_enable),
      .o_enable_clr  (o_enable_clr),
      .i_fifol_empty (i_fifol_empty),
      .i_fifor_empty (i_fifor_empty),
      .i_fifol_data  (i_fifol_data),
      .i_fifor_data  (i_fifor_data),
      .o_fifol_pop   (o_fifol_pop),
      .o_fifor_pop   (o_fifor_pop),
      .o_sck         (o_sck),
      .o_ws          (o_ws),
      .o_sd          (o_sd),
      .o_busy        (o_busy)
   );

   // FIFO storage: write side owned by the stimulus, read side by the monitor
   logic [DW-1:0] mem_l [0:15];
   logic [DW-1:0] mem_r [0:15];
   int wr_l = 0, wr_r = 0, rd_l = 0, rd_r = 0;

   // Enable register model: cleared by the DUT's clear pulse
   logic en_sw = 1'b0;
   int   clr_mark = 0;

   int cyc = 0, pop_pairs = 0, single_pops = 0, clr_cnt = 0, clr_cyc = 0, busy_cnt = 0;
   int max_low = 0, max_high = 0, run_len = 0;
   logic run_lvl = 1'b0, sck_prev = 1'b0;
   int pop_cyc[$];
   int rise_cyc[$];
   logic sd_bits[$];
   logic ws_bits[$];

   int n_tests = 0, n_fail = 0;

   assign i_enable      = en_sw && (clr_cnt == clr_mark);
   assign i_fifol_empty = (rd_l == wr_l);
   assign i_fifor_empty = (rd_r == wr_r);
   assign i_fifol_data  = mem_l[rd_l[3:0]];
   assign i_fifor_data  = mem_r[rd_r[3:0]];

   always @(posedge i_clk) begin
      logic pl, pr, cl;
      pl = o_fifol_pop;
      pr = o_fifor_pop;
      cl = o_enable_clr;
      cyc++;
      #1;
      if (pl && pr) begin
         pop_pairs++;
         pop_cyc.push_back(cyc);
      end
      if (pl != pr) single_pops++;
      if (pl && (rd_l != wr_l)) rd_l++;
      if (pr && (rd_r != wr_r)) rd_r++;
      if (cl) begin
         clr_cnt++;
         clr_cyc = cyc;
      end
   end

   always @(negedge i_clk) begin
      if (o_sck && !sck_prev) begin
         sd_bits.push_back(o_sd);
         ws_bits.push_back(o_ws);
         rise_cyc.push_back(cyc);
      end
      if (o_busy) begin
         busy_cnt++;
         if (o_sck == run_lvl) begin
            run_len++;
         end else begin
            if (run_lvl) begin
               if (run_len > max_high) max_high = run_len;
            end else begin
               if (run_len > max_low) max_low = run_len;
            end
            run_lvl = o_sck;
            run_len = 1;
         end
      end else begin
         run_len = 0;
         run_lvl = 1'b0;
      end
      sck_prev = o_sck;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_l(input logic [DW-1:0] v);
      mem_l[wr_l[3:0]] = v;
      wr_l++;
   endtask

   task automatic push_r(input logic [DW-1:0] v);
      mem_r[wr_r[3:0]] = v;
      wr_r++;
   endtask

   task automatic enable_now();
      clr_mark = clr_cnt;
      en_sw    = 1'b1;
   endtask

   task automatic wait_pop(input int base, input int budget);
      int n = 0;
      while (pop_pairs <= base && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check("pop_seen", 64'(pop_pairs > base), 64'd1);
   endtask

   task automatic wait_clr(input int base, input int budget);
      int n = 0;
      while (clr_cnt <= base && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check("clr_seen", 64'(clr_cnt > base), 64'd1);
   endtask

   // 64 captured bits starting at index start, first capture in the MSB
   function automatic logic [63:0] frame_bits(input int start, input bit use_ws);
      logic [63:0] v = '0;
      for (int i = 0; i < 64; i++) begin
         if (start + i < sd_bits.size()) v[63-i] = use_ws ? ws_bits[start+i] : sd_bits[start+i];
      end
      return v;
   endfunction

   function automatic logic cap_bit(input int idx, input bit use_ws);
      if (idx >= sd_bits.size()) return 1'bx;
      return use_ws ? ws_bits[idx] : sd_bits[idx];
   endfunction

   logic [DW-1:0] t3_l [0:3];
   logic [DW-1:0] t3_r [0:3];

   initial begin
      int b_pop, b_single, b_clr, b_busy, b_rise, en_cyc, rel_cyc, target;
      logic [DW-1:0] l2, r2, l6, r6;

      // Reset with enable high and FIFOs empty
      i_rst_n = 1'b0;
      en_sw   = 1'b1;
      repeat (3) @(negedge i_clk);
      check("reset_outputs", 64'({o_sck, o_ws, o_sd, o_busy, o_enable_clr, o_fifol_pop, o_fifor_pop}), 64'd0);
      rel_cyc = cyc;
      i_rst_n = 1'b1;
      repeat (4) @(negedge i_clk);
      check("reset_clr_count", 64'(clr_cnt), 64'd1);
      check("reset_clr_within_2", 64'((clr_cyc - rel_cyc) <= 2), 64'd1);
      check("reset_no_pops", 64'(pop_pairs + single_pops), 64'd0);
      check("reset_busy_never", 64'(busy_cnt), 64'd0);
      en_sw = 1'b0;

      // Single pair
      l2 = 32'hA5A5_0F0F;
      r2 = 32'h1234_5678;
      @(negedge i_clk);
      b_pop = pop_pairs; b_single = single_pops; b_clr = clr_cnt; b_busy = busy_cnt; b_rise = rise_cyc.size();
      push_l(l2);
      push_r(r2);
      en_cyc = cyc;
      enable_now();
      wait_clr(b_clr, 2000);
      @(negedge i_clk);
      en_sw = 1'b0;
      check("p1_pops", 64'(pop_pairs - b_pop), 64'd1);
      check("p1_single_pops", 64'(single_pops - b_single), 64'd0);
      check("p1_sd_frame", frame_bits(b_rise, 1'b0), {1'b0, l2, r2[31:1]});
      check("p1_sd_tail", 64'(cap_bit(b_rise + 64, 1'b0)), 64'(r2[0]));
      check("p1_ws_frame", frame_bits(b_rise, 1'b1), {32'h0, 32'hFFFF_FFFF});
      check("p1_ws_tail", 64'(cap_bit(b_rise + 64, 1'b1)), 64'd0);
      check("p1_rise_count", 64'(rise_cyc.size() - b_rise), 64'd65);
      check("p1_first_rise_latency", 64'(rise_cyc[b_rise] - en_cyc), 64'(TCLK / 2 + 1));
      check("p1_busy_cycles", 64'(busy_cnt - b_busy), 64'(FRAME + TCLK));
      check("p1_pop_to_clr", 64'(clr_cyc - pop_cyc[b_pop]), 64'(FRAME + TCLK));
      check("p1_done_before_2000", 64'((cyc - en_cyc) < 2000 && !o_busy), 64'd1);

      // Four back-to-back pairs
      t3_l[0] = 32'hDEAD_BEEF; t3_r[0] = 32'h0000_0001;
      t3_l[1] = 32'h0123_4567; t3_r[1] = 32'hCAFE_F00E;
      t3_l[2] = 32'hFFFF_0000; t3_r[2] = 32'h7FFF_FFFF;
      t3_l[3] = 32'h8000_0001; t3_r[3] = 32'h5555_AAAB;
      b_pop = pop_pairs; b_clr = clr_cnt; b_busy = busy_cnt; b_rise = rise_cyc.size();
      for (int i = 0; i < 4; i++) begin
         push_l(t3_l[i]);
         push_r(t3_r[i]);
      end
      enable_now();
      wait_clr(b_clr, 4 * FRAME + 500);
      repeat (3) @(negedge i_clk);
      en_sw = 1'b0;
      check("p4_pops", 64'(pop_pairs - b_pop), 64'd4);
      for (int i = 1; i < 4; i++) begin
         if (b_pop + i < pop_cyc.size())
            check("p4_pop_spacing", 64'(pop_cyc[b_pop+i] - pop_cyc[b_pop+i-1]), 64'(FRAME));
         else
            check("p4_pop_spacing", 64'd0, 64'(FRAME));
      end
      for (int i = 0; i < 4; i++) begin
         check("p4_sd_frame", frame_bits(b_rise + 64 * i, 1'b0),
               {(i == 0) ? 1'b0 : t3_r[(i == 0) ? 0 : i-1][0], t3_l[i], t3_r[i][31:1]});
      end
      check("p4_sd_tail", 64'(cap_bit(b_rise + 256, 1'b0)), 64'(t3_r[3][0]));
      check("p4_rise_count", 64'(rise_cyc.size() - b_rise), 64'd257);
      check("p4_sck_low_run", 64'(max_low), 64'(TCLK / 2));
      check("p4_sck_high_run", 64'(max_high), 64'(TCLK - TCLK / 2));
      check("p4_busy_cycles", 64'(busy_cnt - b_busy), 64'(4 * FRAME + TCLK));
      check("p4_clr_count", 64'(clr_cnt - b_clr), 64'd1);

      // TXR holds two words, TXL one
      b_pop = pop_pairs; b_single = single_pops; b_clr = clr_cnt; b_busy = busy_cnt; b_rise = rise_cyc.size();
      push_l(32'h0F0F_F0F0);
      push_r(32'h1111_1111);
      push_r(32'h2222_2222);
      enable_now();
      wait_clr(b_clr, 2000);
      repeat (3) @(negedge i_clk);
      en_sw = 1'b0;
      check("uneven_pops", 64'(pop_pairs - b_pop), 64'd1);
      check("uneven_single_pops", 64'(single_pops - b_single), 64'd0);
      check("uneven_txr_left", 64'(wr_r - rd_r), 64'd1);
      check("uneven_txl_left", 64'(wr_l - rd_l), 64'd0);
      check("uneven_sd_frame", frame_bits(b_rise, 1'b0), {1'b0, 32'h0F0F_F0F0, 31'h0888_8888});
      check("uneven_busy_cycles", 64'(busy_cnt - b_busy), 64'(FRAME + TCLK));
      check("uneven_clr_count", 64'(clr_cnt - b_clr), 64'd1);
      // Drop the stranded TXR word so later pairs line up
      rd_r = wr_r;

      // Enable dropped at slot 10 of the first frame, three pairs queued
      l6 = 32'hC3C3_3C3C;
      r6 = 32'h600D_F00D;
      push_l(32'hAAAA_5555); push_r(32'h0F0F_0F0F);
      push_l(32'h1357_9BDF); push_r(32'h0123_4567);
      push_l(l6);            push_r(r6);
      @(negedge i_clk);
      b_pop = pop_pairs; b_clr = clr_cnt; b_busy = busy_cnt;
      enable_now();
      wait_pop(b_pop, 10);
      target = (b_pop < pop_cyc.size()) ? pop_cyc[b_pop] + 10 * TCLK : cyc;
      while (cyc < target) @(negedge i_clk);
      en_sw = 1'b0;
      wait_clr(b_clr, 2000);
      repeat (3) @(negedge i_clk);
      check("endrop_pops", 64'(pop_pairs - b_pop), 64'd1);
      check("endrop_txl_left", 64'(wr_l - rd_l), 64'd2);
      check("endrop_txr_left", 64'(wr_r - rd_r), 64'd2);
      check("endrop_busy_cycles", 64'(busy_cnt - b_busy), 64'(FRAME + TCLK));
      check("endrop_clr_count", 64'(clr_cnt - b_clr), 64'd1);

      // Reset at slot 40 (SCK high, right half, R bit 24 = 1), then restart
      b_pop = pop_pairs;
      enable_now();
      wait_pop(b_pop, 10);
      target = (b_pop < pop_cyc.size()) ? pop_cyc[b_pop] + 40 * TCLK + 20 : cyc;
      while (cyc < target) @(negedge i_clk);
      check("rst_pre_outputs", 64'({o_sck, o_ws, o_sd, o_busy}), 64'b1111);
      #2;
      i_rst_n = 1'b0;
      en_sw   = 1'b0;
      #1;
      check("rst_async_outputs", 64'({o_sck, o_ws, o_sd, o_busy, o_enable_clr, o_fifol_pop, o_fifor_pop}), 64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      b_pop = pop_pairs; b_clr = clr_cnt; b_rise = rise_cyc.size();
      enable_now();
      wait_clr(b_clr, 2000);
      repeat (3) @(negedge i_clk);
      en_sw = 1'b0;
      check("restart_pops", 64'(pop_pairs - b_pop), 64'd1);
      check("restart_sd_frame", frame_bits(b_rise, 1'b0), {1'b0, l6, r6[31:1]});
      check("restart_fifos_empty", 64'({i_fifol_empty, i_fifor_empty}), 64'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
